uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serialises bytes onto the UART line, 8N1 by default, with optional parity and two stop bits.
- Counterpart to the team's uart_rx: same CLK_FREQ/BAUD parameterisation, same 30 MHz / 9600 baud defaults, LSB-first framing.
- Sits between the CipherCore output datapath and the tx pin.
- Accepts bytes on a valid/ready handshake and holds one in a one-byte holding register, so back-to-back frames go out with zero idle gap.

Parameters:
CLK_FREQ, 30_000_000, clock frequency in Hz
BAUD, 9600, line baud rate in Hz; DIVIDER = CLK_FREQ/BAUD clocks per bit, integer-truncated, must be >= 2
PARITY, 0, 0 = none, 1 = odd, 2 = even; any other value is treated as none
STOP_BITS, 1, 1 or 2; any other value is treated as 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
tx_data  input  8  byte to send, sampled on handshake
tx_valid  input  1  producer has a byte
tx_ready  output  1  holding register empty; handshake = tx_valid & tx_ready at a rising edge
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress or holding register full
done  output  1  one-cycle pulse after the final stop bit of each frame completes

Behaviour:
- Reset (async assert, sync release):
  - tx=1, tx_ready=1, busy=0, done=0.
  - FSM to IDLE; holding register and baud counter cleared.
  - Asserting rst mid-frame drives tx high immediately and discards both the in-flight and the held byte.
- Frame, in order:
  - start bit (0)
  - d[0]..d[7]
  - parity bit if PARITY!=0: odd = ~^d, even = ^d
  - STOP_BITS stop bits (1)
  - Every bit is held exactly DIVIDER clocks.
- Baud counter:
  - Width $clog2(DIVIDER)+1.
  - Cleared on frame load; counts 0..DIVIDER-1; bit_end strobe at DIVIDER-1.
  - Free-running only while the FSM is not IDLE.
- FSM states and transitions:
  - IDLE -> START: on load.
  - START -> DATA: at bit_end.
  - DATA -> PARITY or STOP: at bit_end with bit index 7; PARITY is skipped when PARITY==0.
  - PARITY -> STOP: at bit_end.
  - STOP: bit_end of the last stop bit ends the frame.
  - Bit index is 3 bits and wraps 7->0 on exit from DATA.
- Load rules:
  - Handshake while FSM IDLE and holding register empty: byte goes straight to the shift register; tx=0 from the cycle after the handshake; holding register stays empty; tx_ready stays 1.
  - Handshake while a frame is active: byte goes to the holding register; tx_ready=0 from the next cycle.
  - At bit_end of the last stop bit, if the holding register is full: it transfers to the shift register, START is entered directly, tx=0 next cycle (zero gap), and tx_ready returns to 1 the next cycle. If it is empty, go to IDLE.
- Ordering and backpressure:
  - tx_ready is registered and equal to ~hold_full. A handshake can never coincide with the holding register emptying; the transfer wins and the producer sees ready one cycle later.
  - Bytes are sent strictly in handshake order; none is dropped or duplicated.
  - tx_data is ignored when tx_valid=0 or tx_ready=0.
- done: pulses 1 cycle, in the cycle after the last stop bit's bit_end, for every frame, including chained frames.
- busy: 1 from the cycle after a handshake until the cycle done pulses with the holding register empty.

Decomposition:
- Package uart_pkg holds the constants shared with uart_rx:
  - DATA_BITS=8
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN
  - FSM state encodings IDLE/START/DATA/PARITY/STOP
  - a divider function returning CLK_FREQ/BAUD
- One sub-module is natural: uart_baud_tick, a clear-able DIVIDER counter emitting bit_end. It is reusable by uart_rx for its half-bit/full-bit timing.

Test Plan:
1. CLK_FREQ=16, BAUD=1 (DIVIDER=16), send 0x55 -> tx low 16 clocks, then bits 1,0,1,0,1,0,1,0 at 16 clocks each, then high 16 clocks; done pulses once at clock 160 after tx falls; busy=0 afterwards.
2. DIVIDER=16, hold tx_valid with 0xA3, 0x0F, 0xFF back-to-back -> three frames with no idle cycle between the stop bit and the next start bit; tx_ready low during each hold; 3 done pulses; a loopback uart_rx decodes 0xA3, 0x0F, 0xFF with valid=1.
3. PARITY=2, STOP_BITS=2, send 0x07 -> parity bit 1, two stop bits; frame is 12 bits = 192 clocks. Repeat with PARITY=1 -> parity bit 0.
4. Assert rst at clock 70 of a 0x00 frame, with a second byte held -> tx=1 in the same cycle; tx_ready=1, busy=0 after release; no done pulse; the held byte is never transmitted.
5. Present tx_valid with tx_data changing every cycle while tx_ready=0 -> only the bytes at handshake edges are transmitted; randomised valid gaps over 200 bytes match a scoreboard exactly.
6. Defaults (30 MHz/9600) -> bit period 3125 clocks ±0, measured on every transition of a 0x55 frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants shared by the UART transmitter and receiver: frame width, parity
// modes, FSM state encoding and the clocks-per-bit divider.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int uart_divider(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Parity bit for a byte; modes other than odd/even yield 0 (unused).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input int mode);
    if (mode == PAR_ODD)  return ~^d;
    if (mode == PAR_EVEN) return ^d;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Clear-able DIVIDER-clock bit timer; bit_end marks the last clock of each bit.
module uart_baud_tick #(
  parameter int DIVIDER = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int CW = $clog2(DIVIDER) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_end ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first framing with optional parity and one or two stop
// bits, plus a one-byte holding register so consecutive frames have no gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 30_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int DIVIDER  = uart_divider(CLK_FREQ, BAUD);
  localparam bit PAR_EN   = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic                 par_q;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic                 bit_end;
  logic                 hs;
  logic                 frame_end;
  logic                 load;
  logic [DATA_BITS-1:0] load_byte;

  assign tx_ready  = ~hold_full;
  assign busy      = (state != ST_IDLE) || hold_full;
  assign hs        = tx_valid && tx_ready;
  assign frame_end = (state == ST_STOP) && bit_end && (TWO_STOP ? stop_idx : 1'b1);
  // A byte offered exactly at frame end bypasses the (empty) holding register.
  assign load      = ((state == ST_IDLE) && hs) || (frame_end && (hold_full || hs));
  assign load_byte = hold_full ? hold : tx_data;

  uart_baud_tick #(
    .DIVIDER(DIVIDER)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (load),
    .en     (state != ST_IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      par_q     <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (hs && !load) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (load && hold_full) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        shreg    <= load_byte;
        par_q    <= parity_bit(load_byte, PARITY);
        tx       <= 1'b0;
        state    <= ST_START;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        if (frame_end) done <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: tx <= 1'b1;
          ST_START: if (bit_end) begin
            state <= ST_DATA;
            tx    <= shreg[0];
          end
          ST_DATA: if (bit_end) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              if (PAR_EN) begin
                state <= ST_PARITY;
                tx    <= par_q;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
          ST_PARITY: if (bit_end) begin
            state    <= ST_STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
          ST_STOP: if (bit_end) begin
            if (frame_end) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
            tx <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (plain, even/2-stop, odd/2-stop, defaults)
// checked clock-by-clock against a frame model built from the framing rules.
module tb_uart_tx;

  localparam int CF [4] = '{16, 16, 16, 30_000_000};
  localparam int BD [4] = '{1, 1, 1, 9600};
  localparam int PR [4] = '{0, 2, 1, 0};
  localparam int SB [4] = '{1, 2, 2, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data_a [4];
  logic [3:0] tx_valid = '0;
  logic [3:0] tx_ready_w, tx_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx #(
      .CLK_FREQ (CF[g]),
      .BAUD     (BD[g]),
      .PARITY   (PR[g]),
      .STOP_BITS(SB[g])
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data_a[g]),
      .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready_w[g]),
      .tx      (tx_w[g]),
      .busy    (busy_w[g]),
      .done    (done_w[g])
    );
  end

  function automatic int div_of(input int k);
    return CF[k] / BD[k];
  endfunction

  function automatic int frame_bits(input int k);
    return 1 + 8 + ((PR[k] == 1 || PR[k] == 2) ? 1 : 0) + ((SB[k] == 2) ? 2 : 1);
  endfunction

  // Expected line level for bit i of the frame carrying byte b.
  function automatic logic exp_bit(input int k, input logic [7:0] b, input int i);
    int ones;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    ones = $countones(b);
    if (i == 9 && PR[k] == 2) return (ones % 2) == 1;
    if (i == 9 && PR[k] == 1) return (ones % 2) == 0;
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input int k, input logic [7:0] b);
    int t;
    t = 0;
    tx_valid[k] = 1'b1;
    while (tx_ready_w[k] !== 1'b1 && t < 14 * div_of(k)) begin
      tx_data_a[k] = 8'($urandom);
      @(negedge clk);
      t++;
    end
    if (tx_ready_w[k] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout inst%0d: tx_ready=%b, required 1 within %0d clocks", k, tx_ready_w[k], t);
      tx_valid[k] = 1'b0;
    end else begin
      tx_data_a[k] = b;
      @(posedge clk);
      exp_q.push_back(b);
      @(negedge clk);
    end
  endtask

  task automatic wait_start(input int k, input int limit);
    int t;
    t = 0;
    while (tx_w[k] !== 1'b0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (tx_w[k] !== 1'b0) begin
      checks++; errors++;
      $display("FAIL start_timeout inst%0d: tx=%b, required 0 within %0d clocks", k, tx_w[k], limit);
    end
  endtask

  // Starts at the negedge of the start bit's first clock; ends at the done cycle.
  task automatic check_frame(input int k, input logic [7:0] b, input string nm);
    int nb, d, bad;
    logic eb;
    nb = frame_bits(k);
    d  = div_of(k);
    for (int i = 0; i < nb; i++) begin
      eb  = exp_bit(k, b, i);
      bad = 0;
      for (int c = 0; c < d; c++) begin
        if (tx_w[k] !== eb) bad++;
        if (!(i == 0 && c == 0) && done_w[k] !== 1'b0) bad++;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s byte=%02h bit%0d: %0d bad clocks, required tx=%b for %0d clocks with done=0",
                 nm, b, i, bad, eb, d);
      end
    end
    checks++;
    if (done_w[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s_done byte=%02h: done=%b, required 1", nm, b, done_w[k]);
    end
  endtask

  task automatic run_frames(input int k, input int n, input bit zero_gap, input string nm);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (zero_gap && i > 0) begin
        checks++;
        if (tx_w[k] !== 1'b0) begin
          errors++;
          $display("FAIL %s_gap frame%0d: tx=%b at done cycle, required 0", nm, i, tx_w[k]);
        end
      end else begin
        wait_start(k, 200 + 14 * div_of(k));
      end
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s_unexpected_frame frame%0d: queue size 0, required a pending byte", nm, i);
        return;
      end
      b = exp_q.pop_front();
      check_frame(k, b, nm);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks += 4;
      if (tx_w[k] !== 1'b1)       begin errors++; $display("FAIL reset_tx inst%0d: %b, required 1", k, tx_w[k]); end
      if (tx_ready_w[k] !== 1'b1) begin errors++; $display("FAIL reset_ready inst%0d: %b, required 1", k, tx_ready_w[k]); end
      if (busy_w[k] !== 1'b0)     begin errors++; $display("FAIL reset_busy inst%0d: %b, required 0", k, busy_w[k]); end
      if (done_w[k] !== 1'b0)     begin errors++; $display("FAIL reset_done inst%0d: %b, required 0", k, done_w[k]); end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    send(0, 8'h55);
    tx_valid[0] = 1'b0;
    checks += 2;
    if (tx_w[0] !== 1'b0)   begin errors++; $display("FAIL single_latency: tx=%b, required 0", tx_w[0]); end
    if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL single_busy: busy=%b, required 1", busy_w[0]); end
    run_frames(0, 1, 1'b0, "single");
    checks += 2;
    if (busy_w[0] !== 1'b0)     begin errors++; $display("FAIL single_busy_end: busy=%b, required 0", busy_w[0]); end
    if (tx_ready_w[0] !== 1'b1) begin errors++; $display("FAIL single_ready_end: tx_ready=%b, required 1", tx_ready_w[0]); end
    @(negedge clk);
    checks++;
    if (done_w[0] !== 1'b0) begin errors++; $display("FAIL single_done_width: done=%b, required 0", done_w[0]); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send(0, 8'hA3);
        send(0, 8'h0F);
        checks++;
        if (tx_ready_w[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_hold: tx_ready=%b, required 0", tx_ready_w[0]); end
        send(0, 8'hFF);
        tx_valid[0] = 1'b0;
      end
      run_frames(0, 3, 1'b1, "b2b");
    join
    checks++;
    if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: busy=%b, required 0", busy_w[0]); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_parity();
    send(1, 8'h07);
    tx_valid[1] = 1'b0;
    run_frames(1, 1, 1'b0, "even_2stop");
    send(2, 8'h07);
    tx_valid[2] = 1'b0;
    run_frames(2, 1, 1'b0, "odd_2stop");
    send(1, 8'hC8);
    tx_valid[1] = 1'b0;
    run_frames(1, 1, 1'b0, "even_2stop");
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int bad;
    send(0, 8'h00);
    send(0, 8'h96);
    tx_valid[0] = 1'b0;
    checks++;
    if (tx_ready_w[0] !== 1'b0) begin errors++; $display("FAIL rstmid_hold: tx_ready=%b, required 0", tx_ready_w[0]); end
    repeat (69) @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pre: tx=%b, required 0", tx_w[0]); end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1) begin errors++; $display("FAIL rstmid_async_tx: tx=%b, required 1", tx_w[0]); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (tx_ready_w[0] !== 1'b1) begin errors++; $display("FAIL rstmid_ready: tx_ready=%b, required 1", tx_ready_w[0]); end
    if (busy_w[0] !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: busy=%b, required 0", busy_w[0]); end
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      if (tx_w[0] !== 1'b1 || done_w[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: %0d clocks with tx!=1 or done!=0, required 0", bad); end
    exp_q.delete();
  endtask

  task automatic test_random_stream();
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 2) == 0) begin
            tx_valid[0] = 1'b0;
            repeat ($urandom_range(1, 20)) begin
              tx_data_a[0] = 8'($urandom);
              @(negedge clk);
            end
          end
          send(0, 8'($urandom));
        end
        tx_valid[0] = 1'b0;
      end
      run_frames(0, 200, 1'b0, "stream");
    join
    repeat (3) @(negedge clk);
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_leftover: %0d bytes untransmitted, required 0", exp_q.size()); end
    if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL stream_busy_end: busy=%b, required 0", busy_w[0]); end
    exp_q.delete();
  endtask

  task automatic test_default_rate();
    send(3, 8'h55);
    tx_valid[3] = 1'b0;
    run_frames(3, 1, 1'b0, "default_rate");
    checks++;
    if (busy_w[3] !== 1'b0) begin errors++; $display("FAIL default_busy_end: busy=%b, required 0", busy_w[3]); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) tx_data_a[k] = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_reset_midframe();
    test_random_stream();
    test_default_rate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
